rxframe_check: RTL and testbench
================================

RXFRAME_CHECK -- requirements
Module: rxframe_check

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two, >=2.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of each error counter.
REQ-004 i_Pclk  in  1  clock; all state changes on rising edge.
REQ-005 i_Rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_Enable  in  1  one-cycle frame strobe; i_Data and i_Parity valid while high.
REQ-007 i_Parity  in  2  mode: 00 none, 01 even, 10 odd, 11 none.
REQ-008 i_Data  in  DATA_WIDTH+3  frame {stop, parity, data[DATA_WIDTH-1:0], start}; start is bit 0.
REQ-009 i_Ready  in  1  consumer accepts o_Data when o_Valid and i_Ready are both high.
REQ-010 i_Clear  in  1  synchronous clear of the counters and o_Overflow.
REQ-011 o_Data  out  DATA_WIDTH  FIFO head data.
REQ-012 o_Valid  out  1  FIFO not empty.
REQ-013 o_Level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 o_Parity_Err_Cnt  out  CNT_WIDTH  count of frames with a parity error.
REQ-015 o_Frame_Err_Cnt  out  CNT_WIDTH  count of frames with start!=0 or stop!=1.
REQ-016 o_Overflow  out  1  sticky; set when a good frame is lost because the FIFO is full.

Function
REQ-017 Stage 1: on the edge where i_Enable=1, SHALL register the data field, the mode, and the parity/framing check results.
REQ-018 Parity check: even mode requires XOR(data, parity)=0; odd mode requires XOR=1; modes 00/11 ignore the parity bit.
REQ-019 Framing check: a frame is bad if bit 0 is 1 or bit DATA_WIDTH+2 is 0, in every mode.
REQ-020 Stage 2, on the next edge:
- Good frame (no parity or framing error): SHALL be pushed into the FIFO.
- Bad frame: SHALL be discarded and never pushed.
REQ-021 A frame with both error types SHALL increment both counters.
REQ-022 Latency: strobe at edge N -> o_Valid=1 and o_Data=frame data after edge N+1, provided the FIFO was empty.
REQ-023 The FIFO SHALL be show-ahead: o_Data is the oldest entry while o_Valid=1.
REQ-024 Pop SHALL occur on an edge where o_Valid=1 and i_Ready=1.
REQ-025 o_Data is don't-care while o_Valid=0, and i_Ready SHALL be ignored then.
REQ-026 Push and pop on the same edge SHALL leave o_Level unchanged; this holds when full.
REQ-027 Overflow: a push while full without a simultaneous pop SHALL drop the frame, set o_Overflow, and leave FIFO contents unchanged.
REQ-028 Back-to-back strobes, one per cycle, SHALL be accepted with no loss while space remains.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH with no gap or duplicate entry.
REQ-030 Counters SHALL saturate at all-ones and not wrap.
REQ-031 If i_Clear and a counter increment or overflow event coincide on the same edge, clear SHALL win (result 0).
REQ-032 i_Clear SHALL NOT affect FIFO contents or the pipeline.

Reset
REQ-033 i_Rst_n=0 SHALL immediately set the following and hold them until release:
- o_Valid=0, o_Level=0, o_Overflow=0, both counters=0, o_Data=0.
- pipeline stage invalid, pointers 0.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight stage-1 frame and all FIFO contents.
REQ-035 The first strobe accepted SHALL be the one sampled on the first rising edge after release.

Verification
REQ-036 Even mode, i_Data=11'b10001101010 -> o_Data=8'd53 after 2 edges; counters stay 0.
REQ-037 Even mode, i_Data=11'b11001101010 -> no push, o_Parity_Err_Cnt=1; odd mode, 11'b10001101000 -> o_Data=8'd52.
REQ-038 i_Data=11'b00001101010 (stop=0) in mode 00 -> dropped, o_Frame_Err_Cnt=1, o_Parity_Err_Cnt=0.
REQ-039 FIFO_DEPTH=4, i_Ready=0, 5 good frames back-to-back:
- o_Level=4 and o_Overflow=1.
- draining then returns the first 4 values in order.
REQ-040 Full FIFO, simultaneous push and pop -> o_Level stays 4 and o_Overflow stays 0.
REQ-041 CNT_WIDTH=2, 5 parity errors -> counter=3; then i_Clear coinciding with a 6th error -> counter=0.

Source files
------------

// File: rtl/rxframe_check.sv
// Serial-frame checker: validates start/stop/parity of one received frame per strobe
// and queues good data words in a show-ahead FIFO with saturating error counters.
module rxframe_check #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          i_Pclk,
  input  logic                          i_Rst_n,
  input  logic                          i_Enable,
  input  logic [1:0]                    i_Parity,
  input  logic [DATA_WIDTH+2:0]         i_Data,
  input  logic                          i_Ready,
  input  logic                          i_Clear,
  output logic [DATA_WIDTH-1:0]         o_Data,
  output logic                          o_Valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_Level,
  output logic [CNT_WIDTH-1:0]          o_Parity_Err_Cnt,
  output logic [CNT_WIDTH-1:0]          o_Frame_Err_Cnt,
  output logic                          o_Overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    MODE_NONE0 = 2'b00,
    MODE_EVEN  = 2'b01,
    MODE_ODD   = 2'b10,
    MODE_NONE3 = 2'b11
  } parity_mode_e;

  // Frame field extraction and checks on the incoming strobe
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_par_bit;
  logic                  in_xor;
  logic                  in_par_err;
  logic                  in_frm_err;
  parity_mode_e          in_mode;

  assign in_data    = i_Data[DATA_WIDTH:1];
  assign in_par_bit = i_Data[DATA_WIDTH+1];
  assign in_xor     = (^in_data) ^ in_par_bit;
  assign in_mode    = parity_mode_e'(i_Parity);
  assign in_par_err = ((in_mode == MODE_EVEN) &&  in_xor) ||
                      ((in_mode == MODE_ODD)  && !in_xor);
  assign in_frm_err = i_Data[0] | ~i_Data[DATA_WIDTH+2];

  // Stage-1 registers
  logic                  s1_valid_q,   s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q,    s1_data_d;
  logic                  s1_par_err_q, s1_par_err_d;
  logic                  s1_frm_err_q, s1_frm_err_d;

  // FIFO and status registers
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         count_q,  count_d;
  logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
  logic [CNT_WIDTH-1:0]  frm_cnt_q, frm_cnt_d;
  logic                  overflow_q, overflow_d;

  logic push, pop, full, fifo_wr, drop;

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d   = i_Enable;
    s1_data_d    = s1_data_q;
    s1_par_err_d = s1_par_err_q;
    s1_frm_err_d = s1_frm_err_q;
    if (i_Enable) begin
      s1_data_d    = in_data;
      s1_par_err_d = in_par_err;
      s1_frm_err_d = in_frm_err;
    end

    push    = s1_valid_q && !s1_par_err_q && !s1_frm_err_q;
    pop     = (count_q != '0) && i_Ready;
    full    = (count_q == LW'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge
    fifo_wr = push && (!full || pop);
    drop    = push && full && !pop;

    wr_ptr_d = fifo_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (fifo_wr && !pop) begin
      count_d = count_q + LW'(1);
    end else if (!fifo_wr && pop) begin
      count_d = count_q - LW'(1);
    end

    par_cnt_d  = par_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    overflow_d = overflow_q;
    if (i_Clear) begin
      par_cnt_d  = '0;
      frm_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (s1_valid_q && s1_par_err_q && (par_cnt_q != '1)) begin
        par_cnt_d = par_cnt_q + CNT_WIDTH'(1);
      end
      if (s1_valid_q && s1_frm_err_q && (frm_cnt_q != '1)) begin
        frm_cnt_d = frm_cnt_q + CNT_WIDTH'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_par_err_q <= 1'b0;
      s1_frm_err_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      par_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_par_err_q <= s1_par_err_d;
      s1_frm_err_q <= s1_frm_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      par_cnt_q    <= par_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through o_Data, which is forced to zero while the FIFO is empty.
  always_ff @(posedge i_Pclk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  assign o_Valid          = (count_q != '0);
  assign o_Data           = o_Valid ? mem_q[rd_ptr_q] : '0;
  assign o_Level          = count_q;
  assign o_Parity_Err_Cnt = par_cnt_q;
  assign o_Frame_Err_Cnt  = frm_cnt_q;
  assign o_Overflow       = overflow_q;

endmodule

// File: tb/tb_rxframe_check.sv
// Scoreboard bench for rxframe_check: a transaction-level model queues the words
// expected to leave the FIFO and a separate monitor compares every cycle.
module tb_rxframe_check;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          i_Enable;
  logic [1:0]    i_Parity;
  logic [DW+2:0] i_Data;
  logic          i_Ready;
  logic          i_Clear;
  logic [DW-1:0] o_Data;
  logic          o_Valid;
  logic [2:0]    o_Level;
  logic [CW-1:0] o_Parity_Err_Cnt;
  logic [CW-1:0] o_Frame_Err_Cnt;
  logic          o_Overflow;

  rxframe_check #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .i_Pclk           (clk),
    .i_Rst_n          (rst_n),
    .i_Enable         (i_Enable),
    .i_Parity         (i_Parity),
    .i_Data           (i_Data),
    .i_Ready          (i_Ready),
    .i_Clear          (i_Clear),
    .o_Data           (o_Data),
    .o_Valid          (o_Valid),
    .o_Level          (o_Level),
    .o_Parity_Err_Cnt (o_Parity_Err_Cnt),
    .o_Frame_Err_Cnt  (o_Frame_Err_Cnt),
    .o_Overflow       (o_Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state; *_prev hold the values visible before the next edge
  int exp_q[$];
  int m_level, m_par, m_frm;
  bit m_ovf;
  int lvl_prev, par_prev, frm_prev;
  bit ovf_prev;
  bit pend_v, pend_pe, pend_fe;
  int pend_data;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit model_par_err(input logic [1:0] mode, input logic [10:0] f);
    int ones;
    ones = $countones(f[9:1]);
    if (mode == 2'b01) return (ones % 2) != 0;
    if (mode == 2'b10) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  function automatic bit model_frm_err(input logic [10:0] f);
    return (f[0] != 1'b0) || (f[10] != 1'b1);
  endfunction

  function automatic logic [10:0] mk_frame(input int data, input logic [1:0] mode,
                                           input bit bad_par, input bit bad_start,
                                           input bit bad_stop);
    logic [7:0] d;
    logic       p;
    int         ones;
    d    = data[7:0];
    ones = $countones(d);
    case (mode)
      2'b01:   p = (ones % 2) != 0;
      2'b10:   p = (ones % 2) == 0;
      default: p = 1'($urandom_range(0, 1));
    endcase
    if (bad_par) p = ~p;
    return {~bad_stop, p, d, bad_start};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_level = 0; m_par = 0; m_frm = 0; m_ovf = 0;
    lvl_prev = 0; par_prev = 0; frm_prev = 0; ovf_prev = 0;
    pend_v = 0; pend_pe = 0; pend_fe = 0; pend_data = 0;
  endtask

  // Drive one cycle of inputs and advance the model over the coming edge
  task automatic apply(input bit en, input logic [1:0] mode, input logic [10:0] frame,
                       input bit rdy, input bit clr);
    bit pop, acc, drop;
    i_Enable = en; i_Parity = mode; i_Data = frame; i_Ready = rdy; i_Clear = clr;
    lvl_prev = m_level; par_prev = m_par; frm_prev = m_frm; ovf_prev = m_ovf;
    pop  = (m_level > 0) && rdy;
    acc  = 0;
    drop = 0;
    if (pend_v && !pend_pe && !pend_fe) begin
      if (m_level < DEPTH || pop) acc = 1;
      else drop = 1;
    end
    if (acc) exp_q.push_back(pend_data);
    m_level = m_level + int'(acc) - int'(pop);
    if (clr) begin
      m_par = 0; m_frm = 0; m_ovf = 0;
    end else begin
      if (pend_v && pend_pe && m_par < CMAX) m_par++;
      if (pend_v && pend_fe && m_frm < CMAX) m_frm++;
      if (drop) m_ovf = 1;
    end
    pend_v    = en;
    pend_pe   = en && model_par_err(mode, frame);
    pend_fe   = en && model_frm_err(frame);
    pend_data = int'(frame[8:1]);
  endtask

  task automatic step(input bit en, input logic [1:0] mode, input logic [10:0] frame,
                      input bit rdy, input bit clr);
    @(negedge clk);
    #1;
    apply(en, mode, frame, rdy, clr);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(0, 2'b00, 11'd0, rdy, 0);
  endtask

  // Assert reset mid-cycle, confirm the asynchronous clear, release a cycle later
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    i_Enable = 0; i_Parity = 0; i_Data = 0; i_Ready = 0; i_Clear = 0;
    model_reset();
    #1;
    check({tag, "_valid"},   o_Valid, 0);
    check({tag, "_level"},   o_Level, 0);
    check({tag, "_data"},    o_Data, 0);
    check({tag, "_par_cnt"}, o_Parity_Err_Cnt, 0);
    check({tag, "_frm_cnt"}, o_Frame_Err_Cnt, 0);
    check({tag, "_ovf"},     o_Overflow, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: samples just before each rising edge, away from both clock edges
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        check("mon_valid",   o_Valid, lvl_prev != 0);
        check("mon_level",   o_Level, lvl_prev);
        check("mon_par_cnt", o_Parity_Err_Cnt, par_prev);
        check("mon_frm_cnt", o_Frame_Err_Cnt, frm_prev);
        check("mon_ovf",     o_Overflow, ovf_prev);
        if (lvl_prev > 0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL mon_data: got %0d expected nothing (scoreboard empty)", o_Data);
          end else begin
            check("mon_data", o_Data, exp_q[0]);
            if (i_Ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    i_Enable = 0; i_Parity = 0; i_Data = 0; i_Ready = 0; i_Clear = 0;
    model_reset();
    do_reset("rst_init");

    // Even mode, good frame: data 53 two edges later, counters untouched
    step(1, 2'b01, 11'b10001101010, 0, 0);
    idle(2, 0);
    #1;
    check("even_good_valid", o_Valid, 1);
    check("even_good_data",  o_Data, 53);
    check("even_good_par",   o_Parity_Err_Cnt, 0);
    check("even_good_frm",   o_Frame_Err_Cnt, 0);
    idle(2, 1);

    // Even mode with bad parity is dropped; odd mode good frame gives 52
    step(1, 2'b01, 11'b11001101010, 0, 0);
    idle(2, 0);
    #1;
    check("even_bad_valid", o_Valid, 0);
    check("even_bad_par",   o_Parity_Err_Cnt, 1);
    step(1, 2'b10, 11'b10001101000, 0, 0);
    idle(2, 0);
    #1;
    check("odd_good_data", o_Data, 52);
    idle(2, 1);

    // Missing stop bit in no-parity mode: framing error only
    step(0, 2'b00, 11'd0, 0, 1);
    step(1, 2'b00, 11'b00001101010, 0, 0);
    idle(2, 0);
    #1;
    check("stop_err_valid", o_Valid, 0);
    check("stop_err_frm",   o_Frame_Err_Cnt, 1);
    check("stop_err_par",   o_Parity_Err_Cnt, 0);

    // Five good frames with no consumer: fourth fills, fifth overflows
    step(0, 2'b00, 11'd0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 2'b01, mk_frame(8'h10 + k, 2'b01, 0, 0, 0), 0, 0);
    idle(2, 0);
    #1;
    check("ovf_level", o_Level, 4);
    check("ovf_flag",  o_Overflow, 1);
    check("ovf_head",  o_Data, 8'h10);
    idle(6, 1);

    // Full FIFO with simultaneous push and pop keeps level and no overflow
    step(0, 2'b00, 11'd0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 2'b10, mk_frame(8'hA0 + k, 2'b10, 0, 0, 0), 0, 0);
    step(1, 2'b10, mk_frame(8'hA4, 2'b10, 0, 0, 0), 0, 0);
    step(0, 2'b00, 11'd0, 1, 0);
    step(0, 2'b00, 11'd0, 0, 0);
    #1;
    check("full_pp_level", o_Level, 4);
    check("full_pp_ovf",   o_Overflow, 0);
    check("full_pp_head",  o_Data, 8'hA1);
    idle(6, 1);

    // Parity counter saturates at 3; clear beats a coinciding increment
    step(0, 2'b00, 11'd0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 2'b01, mk_frame(k * 7, 2'b01, 1, 0, 0), 0, 0);
    idle(2, 0);
    #1;
    check("sat_par_cnt", o_Parity_Err_Cnt, 3);
    step(1, 2'b01, mk_frame(8'h5A, 2'b01, 1, 0, 0), 0, 1);
    step(0, 2'b00, 11'd0, 0, 1);
    step(0, 2'b00, 11'd0, 0, 0);
    #1;
    check("clear_wins_par_cnt", o_Parity_Err_Cnt, 0);

    // Reset with FIFO contents and a frame in flight, then strobe on first edge
    step(1, 2'b01, mk_frame(8'h31, 2'b01, 0, 0, 0), 0, 0);
    step(1, 2'b01, mk_frame(8'h32, 2'b01, 0, 0, 0), 0, 0);
    step(1, 2'b01, mk_frame(8'h33, 2'b01, 0, 0, 0), 0, 0);
    do_reset("rst_mid");
    apply(1, 2'b10, mk_frame(8'hC7, 2'b10, 0, 0, 0), 0, 0);
    idle(2, 0);
    #1;
    check("post_rst_valid", o_Valid, 1);
    check("post_rst_data",  o_Data, 8'hC7);
    check("post_rst_level", o_Level, 1);
    idle(2, 1);

    // Randomized traffic with phases of scarce, balanced and eager consumption
    for (int i = 0; i < 1500; i++) begin
      bit         en, bp, bs, bt, rdy, clr;
      logic [1:0] mode;
      int         rpct;
      en   = $urandom_range(0, 9) < 7;
      mode = 2'($urandom_range(0, 3));
      bp   = $urandom_range(0, 7) == 0;
      bs   = $urandom_range(0, 9) == 0;
      bt   = $urandom_range(0, 9) == 0;
      case ((i / 100) % 3)
        0:       rpct = 10;
        1:       rpct = 50;
        default: rpct = 90;
      endcase
      rdy = $urandom_range(0, 99) < rpct;
      clr = $urandom_range(0, 31) == 0;
      step(en, mode, mk_frame($urandom_range(0, 255), mode, bp, bs, bt), rdy, clr);
    end
    idle(12, 1);
    #1;
    check("final_level",        o_Level, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
